// File: rtl/instr_fetch_unit_pkg.sv
// -----------------------------------------------------------------------------
// instr_fetch_unit_pkg
// Shared constants, types and helpers for the instruction fetch stage.
//   IFETCH_RESET_PC : default byte address fetched first after reset
//   NOP_WORD        : word presented to decode when nothing is buffered
//   INSTR_BYTES     : size of one instruction word in bytes
//   fetch_entry_t   : one buffered fetch, {word, pc}
// -----------------------------------------------------------------------------
package instr_fetch_unit_pkg;

   localparam logic [31:0] IFETCH_RESET_PC = 32'h0000_3000;
   localparam logic [31:0] NOP_WORD        = 32'h0000_0000;
   localparam logic [31:0] INSTR_BYTES     = 32'd4;
   localparam int          FIFO_DEPTH      = 2;

   typedef struct packed {
      logic [31:0] word;
      logic [31:0] pc;
   } fetch_entry_t;

   // Fetch addresses are word aligned; the two low bits of any target are
   // dropped rather than faulted.
   function automatic logic [31:0] align_word_addr(input logic [31:0] addr);
      return addr & ~32'h0000_0003;
   endfunction

   // Sequential successor; wraps modulo 2^32 by plain 32-bit arithmetic.
   function automatic logic [31:0] next_fetch_pc(input logic [31:0] addr);
      return addr + INSTR_BYTES;
   endfunction

endpackage

// File: rtl/instr_fetch_unit_fetch_fifo2.sv
// -----------------------------------------------------------------------------
// fetch_fifo2
// Two-entry {word, pc} buffer between instruction memory and decode.
// Slot 0 is always the head, so the head never moves unless a pop occurs.
// Ports:
//   clk, rst_n   : clock, synchronous active-low reset
//   flush        : synchronous clear of all entries (overrides push/pop)
//   push         : write push_entry at the tail
//   push_entry   : entry to write
//   pop          : drop the head entry
//   head_entry   : current head (meaningless when occupancy == 0)
//   occupancy    : number of valid entries, 0..2
// -----------------------------------------------------------------------------
module fetch_fifo2
   import instr_fetch_unit_pkg::*;
(
   input  logic         clk,
   input  logic         rst_n,
   input  logic         flush,
   input  logic         push,
   input  fetch_entry_t push_entry,
   input  logic         pop,
   output fetch_entry_t head_entry,
   output logic [1:0]   occupancy
);

   fetch_entry_t slot0;
   fetch_entry_t slot1;
   logic [1:0]   count;
   logic         pop_ok;
   logic         push_ok;

   // Defensive qualification: a pop of an empty buffer or a push into a full
   // buffer without a matching pop is ignored instead of corrupting state.
   assign pop_ok  = pop && (count != 2'd0);
   assign push_ok = push && ((count != 2'd2) || pop_ok);

   always_ff @(posedge clk) begin
      if (!rst_n || flush) begin
         count <= 2'd0;
      end else begin
         case ({push_ok, pop_ok})
            2'b10:   count <= count + 2'd1;
            2'b01:   count <= count - 2'd1;
            default: count <= count;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         slot0 <= '0;
         slot1 <= '0;
      end else if (!flush) begin
         case ({push_ok, pop_ok})
            2'b10: begin
               if (count == 2'd0) slot0 <= push_entry;
               else               slot1 <= push_entry;
            end
            2'b01: begin
               slot0 <= slot1;
            end
            2'b11: begin
               // Simultaneous push/pop: occupancy stays the same, the new
               // entry lands behind whatever remains after the pop.
               if (count == 2'd1) begin
                  slot0 <= push_entry;
               end else begin
                  slot0 <= slot1;
                  slot1 <= push_entry;
               end
            end
            default: begin
               slot0 <= slot0;
            end
         endcase
      end
   end

   assign head_entry = slot0;
   assign occupancy  = count;

endmodule

// File: rtl/instr_fetch_unit.sv
// -----------------------------------------------------------------------------
// instr_fetch_unit
// Instruction fetch stage: owns the PC, issues sequential word reads to a
// synchronous instruction memory (data one cycle after the request), buffers
// returned words in a 2-entry queue and hands them to decode over valid/ready.
// Redirects squash everything in flight and buffered.
//
// Optional build macro: IFETCH_STAT_EN adds the fetch_count port and counter.
//
// Parameters:
//   RESET_PC       : byte address fetched first after reset
// Ports:
//   clk            : sole clock, rising edge
//   rst_n          : synchronous active-low reset
//   im_req         : read request to instruction memory this cycle
//   im_addr        : request byte address (word aligned, 0 when idle)
//   im_rdata       : read data for the request of the previous cycle
//   redirect_valid : taken branch/jump/exception redirect
//   redirect_pc    : redirect target, low two bits ignored
//   instr_valid    : instr_word/instr_pc hold a fetched instruction
//   instr_ready    : decode accepts the instruction this cycle
//   instr_word     : fetched instruction word (NOP when not valid)
//   instr_pc       : byte address of instr_word (0 when not valid)
//   fetch_count    : accepted-instruction count (IFETCH_STAT_EN only)
// -----------------------------------------------------------------------------
module instr_fetch_unit
   import instr_fetch_unit_pkg::*;
#(
   parameter logic [31:0] RESET_PC = IFETCH_RESET_PC
) (
   input  logic        clk,
   input  logic        rst_n,
   output logic        im_req,
   output logic [31:0] im_addr,
   input  logic [31:0] im_rdata,
   input  logic        redirect_valid,
   input  logic [31:0] redirect_pc,
   output logic        instr_valid,
   input  logic        instr_ready,
   output logic [31:0] instr_word,
   output logic [31:0] instr_pc
`ifdef IFETCH_STAT_EN
   ,
   output logic [31:0] fetch_count
`endif
);

   logic [31:0]  pc;
   logic         inflight;
   logic [31:0]  inflight_pc;

   logic [1:0]   occupancy;
   fetch_entry_t head_entry;
   fetch_entry_t push_entry;
   logic         pop;
   logic         push;
   logic [2:0]   backlog;

   assign pop = instr_valid & instr_ready;

   // A response is only kept if its request survived: a redirect in the
   // response cycle discards it, and reset clears inflight so a response to
   // a pre-reset request is never captured.
   assign push = inflight & ~redirect_valid;

   assign push_entry.word = im_rdata;
   assign push_entry.pc   = inflight_pc;

   // Words that will occupy the buffer next cycle if nothing new is issued.
   // A pop this cycle frees a slot immediately, which is what lets a stalled
   // stream resume issuing in the same cycle decode takes the head.
   assign backlog = {1'b0, occupancy} + {2'b00, inflight} - {2'b00, pop};

   always_comb begin
      im_req  = 1'b0;
      im_addr = '0;
      if (rst_n && !redirect_valid && (backlog < 3'd2)) begin
         im_req  = 1'b1;
         im_addr = pc;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         pc          <= align_word_addr(RESET_PC);
         inflight    <= 1'b0;
         inflight_pc <= '0;
      end else if (redirect_valid) begin
         pc       <= align_word_addr(redirect_pc);
         inflight <= 1'b0;
      end else begin
         inflight <= im_req;
         if (im_req) begin
            pc          <= next_fetch_pc(pc);
            inflight_pc <= pc;
         end
      end
   end

   // Flushing on redirect also covers a pop in the same cycle: decode has
   // already taken the head, the flush just discards what remains.
   fetch_fifo2 u_fifo (
      .clk        (clk),
      .rst_n      (rst_n),
      .flush      (redirect_valid),
      .push       (push),
      .push_entry (push_entry),
      .pop        (pop),
      .head_entry (head_entry),
      .occupancy  (occupancy)
   );

   always_comb begin
      instr_valid = 1'b0;
      instr_word  = NOP_WORD;
      instr_pc    = '0;
      if (occupancy != 2'd0) begin
         instr_valid = 1'b1;
         instr_word  = head_entry.word;
         instr_pc    = head_entry.pc;
      end
   end

`ifdef IFETCH_STAT_EN
   // Counts accepted instructions; redirects do not touch it.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         fetch_count <= '0;
      end else if (pop) begin
         fetch_count <= fetch_count + 32'd1;
      end
   end
`endif

endmodule

// File: tb/tb_instr_fetch_unit.sv
`timescale 1ns/1ps
module tb_instr_fetch_unit;
   import instr_fetch_unit_pkg::*;

   localparam logic [31:0] RST_PC = 32'h0000_3000;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        im_req;
   logic [31:0] im_addr;
   logic [31:0] im_rdata;
   logic        redirect_valid;
   logic [31:0] redirect_pc;
   logic        instr_valid;
   logic        instr_ready;
   logic [31:0] instr_word;
   logic [31:0] instr_pc;
`ifdef IFETCH_STAT_EN
   logic [31:0] fetch_count;
`endif

   int total = 0;
   int bad   = 0;
   int cyc   = 0;
   bit mon_en = 1'b0;
   int pops_seen = 0;

   // Scoreboard: expected accepted-instruction PCs, pushed by stimulus.
   logic [31:0] exp_q[$];
   logic [31:0] stream_next;

   // Reference model state: issue cycles of live requests, next request PC.
   int          req_times[$];
   logic [31:0] next_req_pc;
   logic [31:0] model_count;

   instr_fetch_unit #(.RESET_PC(RST_PC)) dut (
      .clk            (clk),
      .rst_n          (rst_n),
      .im_req         (im_req),
      .im_addr        (im_addr),
      .im_rdata       (im_rdata),
      .redirect_valid (redirect_valid),
      .redirect_pc    (redirect_pc),
      .instr_valid    (instr_valid),
      .instr_ready    (instr_ready),
      .instr_word     (instr_word),
      .instr_pc       (instr_pc)
`ifdef IFETCH_STAT_EN
      ,
      .fetch_count    (fetch_count)
`endif
   );

   always #5 clk = ~clk;

   function automatic logic [31:0] mem_word(input logic [31:0] a);
      return {a[15:0], a[31:16]} ^ 32'h1357_9BDF;
   endfunction

   // Synchronous instruction memory; garbage on cycles with no request.
   always @(posedge clk) begin
      if (im_req === 1'b1) im_rdata <= mem_word(im_addr);
      else                 im_rdata <= $urandom;
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s cyc=%0d got=%h want=%h", name, cyc, act, exp);
      end
   endtask

   always @(negedge clk) begin : monitor
      bit          m_valid;
      bit          m_pop;
      bit          m_req;
      #2;
      cyc++;
      if (mon_en) begin
         m_valid = (req_times.size() > 0) && (req_times[0] <= cyc - 2);
         check("instr_valid", {31'b0, instr_valid}, {31'b0, m_valid});
         if (m_valid) begin
            if (exp_q.size() == 0) begin
               total++;
               bad++;
               $display("FAIL scoreboard_empty cyc=%0d got_pc=%h want=none", cyc, instr_pc);
            end else begin
               check("instr_pc", instr_pc, exp_q[0]);
               check("instr_word", instr_word, mem_word(exp_q[0]));
            end
         end else begin
            check("idle_pc", instr_pc, 32'h0);
            check("idle_word", instr_word, NOP_WORD);
         end

         m_pop = m_valid && (instr_ready === 1'b1) && (rst_n === 1'b1);
         m_req = (rst_n === 1'b1) && (redirect_valid === 1'b0) &&
                 ((req_times.size() - int'(m_pop)) < 2);
         check("im_req", {31'b0, im_req}, {31'b0, m_req});
         if (m_req) check("im_addr", im_addr, next_req_pc);
         if (rst_n !== 1'b1) check("im_addr_rst", im_addr, 32'h0);
`ifdef IFETCH_STAT_EN
         check("fetch_count", fetch_count, model_count);
`endif

         if (m_pop) begin
            if (exp_q.size() > 0) void'(exp_q.pop_front());
            if (req_times.size() > 0) void'(req_times.pop_front());
            pops_seen++;
            model_count = model_count + 32'd1;
         end
         if (m_req) begin
            req_times.push_back(cyc);
            next_req_pc = next_req_pc + 32'd4;
         end
         if (rst_n !== 1'b1) begin
            req_times.delete();
            next_req_pc = RST_PC;
            model_count = 32'h0;
         end else if (redirect_valid === 1'b1) begin
            req_times.delete();
            next_req_pc = redirect_pc & ~32'h3;
         end
      end
   end

   // One cycle of stimulus; redirect/reset restarts the expected stream
   // after the monitor has retired any pop of this cycle.
   task automatic step(input bit rdy, input bit rv, input logic [31:0] rpc, input bit rn);
      @(negedge clk);
      instr_ready    = rdy;
      redirect_valid = rv;
      redirect_pc    = rv ? rpc : $urandom;
      rst_n          = rn;
      #3;
      if (!rn || rv) begin
         exp_q.delete();
         stream_next = !rn ? RST_PC : (rpc & ~32'h3);
      end
      while (exp_q.size() < 8) begin
         exp_q.push_back(stream_next);
         stream_next = stream_next + 32'd4;
      end
   endtask

   initial begin
      int          rdy_pct;
      bit          rn;
      bit          rv;
      logic [31:0] rpc;

      rst_n          = 1'b0;
      instr_ready    = 1'b0;
      redirect_valid = 1'b0;
      redirect_pc    = 32'h0;
      im_rdata       = 32'h0;
      model_count    = 32'h0;
      next_req_pc    = RST_PC;
      stream_next    = RST_PC;

      step(0, 0, 0, 0);
      step(0, 0, 0, 0);
      mon_en = 1'b1;
      step(0, 0, 0, 0);

      // Streaming with ready held high.
      repeat (8) step(1, 0, 0, 1);

      // Decode stalled for the first seven cycles, then drains.
      step(0, 0, 0, 0);
      repeat (7) step(0, 0, 0, 1);
      repeat (8) step(1, 0, 0, 1);

      // Redirect to an unaligned target with two words buffered.
      step(0, 0, 0, 0);
      repeat (6) step(0, 0, 0, 1);
      step(0, 1, 32'h0000_4002, 1);
      repeat (10) step(1, 0, 0, 1);

      // Redirect in the same cycle decode accepts 0x3010.
      step(0, 0, 0, 0);
      repeat (6) step(1, 0, 0, 1);
      step(1, 1, 32'h0000_5000, 1);
      repeat (8) step(1, 0, 0, 1);

      // One-cycle reset in the middle of a stream.
      repeat (6) step(1, 0, 0, 1);
      step(1, 0, 0, 0);
      repeat (8) step(1, 0, 0, 1);

      // Wrap-around of the PC.
      step(1, 1, 32'hFFFF_FFF5, 1);
      repeat (8) step(1, 0, 0, 1);

      // Randomized traffic with varying decode back-pressure.
      rdy_pct = 75;
      for (int i = 0; i < 3000; i++) begin
         if ((i % 200) == 0) rdy_pct = $urandom_range(10, 100);
         rn  = ($urandom_range(0, 99) != 0);
         rv  = rn && ($urandom_range(0, 15) == 0);
         rpc = ($urandom_range(0, 3) == 0) ? (32'hFFFF_FFF0 | ($urandom & 32'hF)) : $urandom;
         step($urandom_range(1, 100) <= rdy_pct, rv, rpc, rn);
      end
      repeat (4) step(1, 0, 0, 1);

      check("progress", {31'b0, pops_seen >= 500}, 32'h1);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
